// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch sequencer between the PC register and the IF/ID pipeline
// register. It reads the instruction at the current PC over a req/ack memory
// port and drives the PC's Stall input, so the PC advances only when an
// instruction is handed downstream or a redirect (Flush) happens. A one-entry
// hold buffer absorbs an acknowledge that arrives while IF/ID is stalled. A
// request abandoned by a Flush is drained in DROP with its address held in
// Saved_Addr. A sticky error flag reports a memory that never acknowledges.
//
// Ports:
//   Clk, Rst          clock (rising edge), synchronous active-high reset
//   Pc_In             current PC value
//   Pc_Stall          to PC Stall input (0 = PC loads its next value)
//   Mem_Req/Mem_Addr  instruction memory read request and address
//   Mem_Ack/Mem_RData acknowledge and instruction word (same cycle)
//   Id_Stall          downstream stall, IF/ID outputs hold
//   Flush             redirect, the PC's next value is the target
//   Inst_Out/Pc_Out   registered instruction and its address
//   Inst_Valid        registered, 0 = bubble
//   Fetch_Err         sticky memory-timeout flag
// ----------------------------------------------------------------------------
module if_fetch_unit #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Pc_In,
    output logic        Pc_Stall,
    output logic        Mem_Req,
    output logic [31:0] Mem_Addr,
    input  logic        Mem_Ack,
    input  logic [31:0] Mem_RData,
    input  logic        Id_Stall,
    input  logic        Flush,
    output logic [31:0] Inst_Out,
    output logic [31:0] Pc_Out,
    output logic        Inst_Valid,
    output logic        Fetch_Err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t             state_q, state_d;
    logic [31:0]        saved_addr_q, saved_addr_d;
    logic [31:0]        hold_inst_q, hold_inst_d;
    logic [31:0]        hold_pc_q, hold_pc_d;
    logic [31:0]        inst_out_q, inst_out_d;
    logic [31:0]        pc_out_q, pc_out_d;
    logic               inst_valid_q, inst_valid_d;
    logic               fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               release_pc;
    logic               req_c;

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= S_IDLE;
            saved_addr_q <= '0;
            hold_inst_q  <= '0;
            hold_pc_q    <= '0;
            inst_out_q   <= '0;
            pc_out_q     <= '0;
            inst_valid_q <= 1'b0;
            fetch_err_q  <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            saved_addr_q <= saved_addr_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
            inst_out_q   <= inst_out_d;
            pc_out_q     <= pc_out_d;
            inst_valid_q <= inst_valid_d;
            fetch_err_q  <= fetch_err_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        saved_addr_d = saved_addr_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        inst_out_d   = inst_out_q;
        pc_out_d     = pc_out_q;
        inst_valid_d = inst_valid_q;
        release_pc   = 1'b0;
        req_c        = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                req_c        = 1'b1;
                // Tracked every cycle so a Flush can hand the live address to DROP.
                saved_addr_d = Pc_In;
                if (Flush) begin
                    // Ack in the same cycle is dropped; otherwise drain it in DROP.
                    release_pc   = 1'b1;
                    inst_valid_d = 1'b0;
                    inst_out_d   = '0;
                    state_d      = Mem_Ack ? S_WAIT : S_DROP;
                end else if (Mem_Ack && !Id_Stall) begin
                    release_pc   = 1'b1;
                    inst_out_d   = Mem_RData;
                    pc_out_d     = Pc_In;
                    inst_valid_d = 1'b1;
                end else if (Mem_Ack) begin
                    // Downstream busy: park the word, PC stays put until delivery.
                    hold_inst_d = Mem_RData;
                    hold_pc_d   = Pc_In;
                    state_d     = S_HOLD;
                end else if (!Id_Stall) begin
                    inst_valid_d = 1'b0;
                end
            end

            S_HOLD: begin
                if (Flush) begin
                    release_pc   = 1'b1;
                    inst_valid_d = 1'b0;
                    inst_out_d   = '0;
                    state_d      = S_WAIT;
                end else if (!Id_Stall) begin
                    release_pc   = 1'b1;
                    inst_out_d   = hold_inst_q;
                    pc_out_d     = hold_pc_q;
                    inst_valid_d = 1'b1;
                    state_d      = S_WAIT;
                end
            end

            S_DROP: begin
                req_c = 1'b1;
                if (Mem_Ack) begin
                    state_d = S_WAIT;
                end
                if (Flush) begin
                    // A newer redirect may still load the PC; the old request drains on.
                    release_pc   = 1'b1;
                    inst_valid_d = 1'b0;
                    inst_out_d   = '0;
                end else if (!Id_Stall) begin
                    inst_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Timeout: count un-acked request cycles, saturate, latch the error.
    always_comb begin
        cnt_d = '0;
        if (req_c && !Mem_Ack) begin
            cnt_d = (cnt_q == TO_VAL) ? cnt_q : cnt_q + CNT_W'(1);
        end
        fetch_err_d = fetch_err_q | (cnt_d == TO_VAL);
    end

    // Rst is synchronous, so state_q can still be WAIT/DROP during a reset cycle.
    assign Mem_Req    = req_c & ~Rst;
    assign Pc_Stall   = Rst | ~release_pc;
    assign Mem_Addr   = (state_q == S_DROP) ? saved_addr_q : Pc_In;
    assign Inst_Out   = inst_out_q;
    assign Pc_Out     = pc_out_q;
    assign Inst_Valid = inst_valid_q;
    assign Fetch_Err  = fetch_err_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] Pc_In;
    logic        Pc_Stall;
    logic        Mem_Req;
    logic [31:0] Mem_Addr;
    logic        Mem_Ack = 1'b0;
    logic [31:0] Mem_RData;
    logic        Id_Stall = 1'b0;
    logic        Flush = 1'b0;
    logic [31:0] Inst_Out;
    logic [31:0] Pc_Out;
    logic        Inst_Valid;
    logic        Fetch_Err;
    logic [31:0] tgt = 32'h0;

    int nvec = 0;
    int nerr = 0;

    if_fetch_unit #(.TIMEOUT(4), .CNT_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .Pc_In(Pc_In), .Pc_Stall(Pc_Stall),
        .Mem_Req(Mem_Req), .Mem_Addr(Mem_Addr), .Mem_Ack(Mem_Ack),
        .Mem_RData(Mem_RData), .Id_Stall(Id_Stall), .Flush(Flush),
        .Inst_Out(Inst_Out), .Pc_Out(Pc_Out), .Inst_Valid(Inst_Valid),
        .Fetch_Err(Fetch_Err)
    );

    always #5 Clk = ~Clk;

    // Environment: PC register and a memory whose data is addr + 0x100.
    always @(posedge Clk) begin
        if (Rst) Pc_In <= 32'h0;
        else if (!Pc_Stall) Pc_In <= Flush ? tgt : Pc_In + 32'd4;
    end
    assign Mem_RData = Mem_Addr + 32'h100;

    // Leaves the bench mid-way through the IDLE cycle following reset.
    task automatic do_reset();
        @(negedge Clk);
        Rst = 1'b1; Mem_Ack = 1'b0; Id_Stall = 1'b0; Flush = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        nvec++; if (Mem_Req !== 1'b0) begin nerr++; $display("FAIL rst_req got=%b exp=0", Mem_Req); end
        nvec++; if (Pc_Stall !== 1'b1) begin nerr++; $display("FAIL rst_stall got=%b exp=1", Pc_Stall); end
        nvec++; if ({Inst_Valid, Fetch_Err} !== 2'b00) begin nerr++; $display("FAIL rst_flags got=%b exp=00", {Inst_Valid, Fetch_Err}); end
        nvec++; if ({Inst_Out, Pc_Out} !== 64'h0) begin nerr++; $display("FAIL rst_data got=%h exp=0", {Inst_Out, Pc_Out}); end
    endtask

    task automatic test_zero_wait();
        do_reset();
        @(negedge Clk); Mem_Ack = 1'b1; #1;
        nvec++; if (Mem_Req !== 1'b1 || Mem_Addr !== 32'h0) begin nerr++; $display("FAIL zw_first req=%b addr=%h exp=1/0", Mem_Req, Mem_Addr); end
        nvec++; if (Pc_Stall !== 1'b0) begin nerr++; $display("FAIL zw_stall0 got=%b exp=0", Pc_Stall); end
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk); #1;
            nvec++; if (Inst_Valid !== 1'b1 || Pc_Out !== 32'(4*k)) begin nerr++; $display("FAIL zw_out k=%0d valid=%b pc=%h exp=1/%h", k, Inst_Valid, Pc_Out, 32'(4*k)); end
            nvec++; if (Inst_Out !== 32'(4*k + 256)) begin nerr++; $display("FAIL zw_inst k=%0d got=%h exp=%h", k, Inst_Out, 32'(4*k + 256)); end
            nvec++; if (Pc_Stall !== 1'b0) begin nerr++; $display("FAIL zw_stall k=%0d got=%b exp=0", k, Pc_Stall); end
        end
    endtask

    task automatic test_two_wait();
        do_reset();
        for (int f = 0; f < 4; f++) begin
            for (int j = 0; j < 3; j++) begin
                @(negedge Clk); Mem_Ack = (j == 2); #1;
                nvec++; if (Mem_Req !== 1'b1 || Mem_Addr !== 32'(4*f)) begin nerr++; $display("FAIL tw_addr f=%0d j=%0d req=%b addr=%h exp=1/%h", f, j, Mem_Req, Mem_Addr, 32'(4*f)); end
                nvec++; if (Pc_Stall !== (j != 2)) begin nerr++; $display("FAIL tw_stall f=%0d j=%0d got=%b exp=%b", f, j, Pc_Stall, j != 2); end
                nvec++; if (Inst_Valid !== (j == 0 && f > 0)) begin nerr++; $display("FAIL tw_valid f=%0d j=%0d got=%b exp=%b", f, j, Inst_Valid, (j == 0 && f > 0)); end
                if (j == 0 && f > 0) begin
                    nvec++; if (Pc_Out !== 32'(4*(f-1))) begin nerr++; $display("FAIL tw_pc f=%0d got=%h exp=%h", f, Pc_Out, 32'(4*(f-1))); end
                end
            end
        end
        nvec++; if (Fetch_Err !== 1'b0) begin nerr++; $display("FAIL tw_err got=%b exp=0", Fetch_Err); end
    endtask

    task automatic test_id_stall();
        do_reset();
        @(negedge Clk); Mem_Ack = 1'b1;                     // addr 0
        @(negedge Clk);                                     // addr 4
        @(negedge Clk); Id_Stall = 1'b1; #1;                // addr 8 acked while stalled
        nvec++; if (Pc_Stall !== 1'b1 || Mem_Addr !== 32'h8) begin nerr++; $display("FAIL ids_ack stall=%b addr=%h exp=1/8", Pc_Stall, Mem_Addr); end
        for (int k = 0; k < 2; k++) begin
            @(negedge Clk); #1;
            nvec++; if (Mem_Req !== 1'b0 || Pc_Stall !== 1'b1) begin nerr++; $display("FAIL ids_hold k=%0d req=%b stall=%b exp=0/1", k, Mem_Req, Pc_Stall); end
            nvec++; if (Pc_Out !== 32'h4 || Inst_Out !== 32'h104 || Inst_Valid !== 1'b1) begin nerr++; $display("FAIL ids_out k=%0d pc=%h inst=%h v=%b exp=4/104/1", k, Pc_Out, Inst_Out, Inst_Valid); end
        end
        @(negedge Clk); Id_Stall = 1'b0; #1;
        nvec++; if (Pc_Stall !== 1'b0 || Pc_Out !== 32'h4) begin nerr++; $display("FAIL ids_rel stall=%b pc=%h exp=0/4", Pc_Stall, Pc_Out); end
        @(negedge Clk); #1;
        nvec++; if (Pc_Out !== 32'h8 || Inst_Out !== 32'h108 || Inst_Valid !== 1'b1) begin nerr++; $display("FAIL ids_deliv pc=%h inst=%h v=%b exp=8/108/1", Pc_Out, Inst_Out, Inst_Valid); end
        nvec++; if (Mem_Req !== 1'b1 || Mem_Addr !== 32'hC) begin nerr++; $display("FAIL ids_next req=%b addr=%h exp=1/c", Mem_Req, Mem_Addr); end
    endtask

    task automatic test_flush_before_ack();
        do_reset();
        Mem_Ack = 1'b1;
        repeat (4) @(negedge Clk);                          // addrs 0,4,8,C
        @(negedge Clk); Mem_Ack = 1'b0; Flush = 1'b1; tgt = 32'h40; #1;
        nvec++; if (Mem_Addr !== 32'h10 || Pc_Stall !== 1'b0) begin nerr++; $display("FAIL fb_flush addr=%h stall=%b exp=10/0", Mem_Addr, Pc_Stall); end
        @(negedge Clk); Flush = 1'b0; #1;
        nvec++; if (Mem_Req !== 1'b1 || Mem_Addr !== 32'h10 || Pc_Stall !== 1'b1) begin nerr++; $display("FAIL fb_drop req=%b addr=%h stall=%b exp=1/10/1", Mem_Req, Mem_Addr, Pc_Stall); end
        nvec++; if (Inst_Valid !== 1'b0 || Inst_Out !== 32'h0) begin nerr++; $display("FAIL fb_bubble v=%b inst=%h exp=0/0", Inst_Valid, Inst_Out); end
        @(negedge Clk); Mem_Ack = 1'b1; #1;
        nvec++; if (Mem_Addr !== 32'h10 || Pc_Stall !== 1'b1) begin nerr++; $display("FAIL fb_dack addr=%h stall=%b exp=10/1", Mem_Addr, Pc_Stall); end
        @(negedge Clk); #1;
        nvec++; if (Mem_Addr !== 32'h40 || Inst_Valid !== 1'b0) begin nerr++; $display("FAIL fb_tgt addr=%h v=%b exp=40/0", Mem_Addr, Inst_Valid); end
        @(negedge Clk); #1;
        nvec++; if (Pc_Out !== 32'h40 || Inst_Out !== 32'h140 || Inst_Valid !== 1'b1) begin nerr++; $display("FAIL fb_deliv pc=%h inst=%h v=%b exp=40/140/1", Pc_Out, Inst_Out, Inst_Valid); end
    endtask

    task automatic test_flush_on_ack();
        do_reset();
        @(negedge Clk); Mem_Ack = 1'b1;                     // addr 0
        @(negedge Clk); Flush = 1'b1; tgt = 32'h80; #1;     // addr 4 acked + flushed
        nvec++; if (Pc_Stall !== 1'b0) begin nerr++; $display("FAIL fa_stall got=%b exp=0", Pc_Stall); end
        @(negedge Clk); Flush = 1'b0; Mem_Ack = 1'b0; #1;
        nvec++; if (Inst_Valid !== 1'b0 || Inst_Out !== 32'h0) begin nerr++; $display("FAIL fa_out v=%b inst=%h exp=0/0", Inst_Valid, Inst_Out); end
        nvec++; if (Mem_Req !== 1'b1 || Mem_Addr !== 32'h80) begin nerr++; $display("FAIL fa_tgt req=%b addr=%h exp=1/80", Mem_Req, Mem_Addr); end
    endtask

    task automatic test_timeout_reset();
        do_reset();
        @(negedge Clk); Mem_Ack = 1'b1;                     // addr 0
        @(negedge Clk);                                     // addr 4
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clk); Mem_Ack = 1'b0; #1;
            nvec++; if (Fetch_Err !== 1'b0) begin nerr++; $display("FAIL to_early k=%0d got=%b exp=0", k, Fetch_Err); end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk); #1;
            nvec++; if (Fetch_Err !== 1'b1 || Mem_Req !== 1'b1) begin nerr++; $display("FAIL to_err k=%0d err=%b req=%b exp=1/1", k, Fetch_Err, Mem_Req); end
        end
        nvec++; if (Pc_Out !== 32'h4 || Inst_Out !== 32'h104) begin nerr++; $display("FAIL to_keep pc=%h inst=%h exp=4/104", Pc_Out, Inst_Out); end
        @(negedge Clk); Rst = 1'b1; #1;
        nvec++; if (Mem_Req !== 1'b0 || Pc_Stall !== 1'b1) begin nerr++; $display("FAIL to_rstcomb req=%b stall=%b exp=0/1", Mem_Req, Pc_Stall); end
        @(negedge Clk); #1;
        nvec++; if ({Fetch_Err, Inst_Valid} !== 2'b00 || {Pc_Out, Inst_Out} !== 64'h0) begin nerr++; $display("FAIL to_rstclr err=%b v=%b pc=%h inst=%h exp=0", Fetch_Err, Inst_Valid, Pc_Out, Inst_Out); end
        Rst = 1'b0; #1;
        nvec++; if (Mem_Req !== 1'b0) begin nerr++; $display("FAIL to_idle req=%b exp=0", Mem_Req); end
        @(negedge Clk); #1;
        nvec++; if (Mem_Req !== 1'b1 || Mem_Addr !== 32'h0) begin nerr++; $display("FAIL to_restart req=%b addr=%h exp=1/0", Mem_Req, Mem_Addr); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_two_wait();
        test_id_stall();
        test_flush_before_ack();
        test_flush_on_ack();
        test_timeout_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch sequencer between the program counter register and the IF/ID pipeline register. It takes the current PC value and issues a request/acknowledge read to instruction memory. It drives the PC's Stall input so the PC advances only when a fetched instruction is delivered or a redirect occurs. It also absorbs downstream stalls and branch flushes, and flags a memory that never acknowledges.

## Interface
- TIMEOUT, 255: number of consecutive un-acknowledged request cycles before Fetch_Err is set; range 1..2^CNT_W-1.
- CNT_W, 8: width of the timeout counter.
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, synchronous, active-high.
- Pc_In  in  32  current PC value (PC register output).
- Pc_Stall  out  1  to the PC Stall input; 0 lets the PC load its next value at the coming edge.
- Mem_Req  out  1  instruction-memory read request.
- Mem_Addr  out  32  read address, valid while Mem_Req=1.
- Mem_Ack  in  1  memory acknowledge; Mem_RData is valid in the same cycle.
- Mem_RData  in  32  instruction word.
- Id_Stall  in  1  downstream stall; IF/ID outputs must hold.
- Flush  in  1  branch/jump redirect; the PC's next value is the target.
- Inst_Out  out  32  registered instruction to IF/ID.
- Pc_Out  out  32  registered address of Inst_Out.
- Inst_Valid  out  1  registered; Inst_Out is a real instruction (0 = bubble).
- Fetch_Err  out  1  sticky; memory timeout occurred.

## Operation
- **State register.** States: IDLE, WAIT, HOLD, DROP. Saved_Addr is a 32-bit register. The hold buffer stores one instruction and its PC.
- **Combinational outputs.**
  - Mem_Req = 1 in WAIT and DROP.
  - Mem_Addr = Saved_Addr in DROP, otherwise Pc_In.
  - Pc_Stall = 1 unless a "release" condition below applies.
- **IDLE.** Mem_Req=0, Pc_Stall=1. Moves to WAIT unconditionally.
- **WAIT.** Saved_Addr <= Pc_In every cycle. Cases are evaluated in this priority order:
  - Flush: release. With Mem_Ack, the data is discarded and the state stays WAIT; without Mem_Ack, go to DROP. Inst_Valid <= 0, Inst_Out <= 0.
  - Mem_Ack and !Id_Stall: release. Inst_Out <= Mem_RData, Pc_Out <= Pc_In, Inst_Valid <= 1. Stay in WAIT.
  - Mem_Ack and Id_Stall: the hold buffer takes {Mem_RData, Pc_In}. Outputs hold. Go to HOLD.
  - No Mem_Ack: if !Id_Stall, Inst_Valid <= 0; if Id_Stall, outputs hold.
- **HOLD.** Mem_Req=0.
  - Flush: release, discard the buffer, Inst_Valid <= 0, go to WAIT.
  - !Id_Stall: release, outputs <= buffer, Inst_Valid <= 1, go to WAIT.
  - Otherwise: hold.
- **DROP.** The old request stays outstanding at Saved_Addr.
  - Mem_Ack: discard the data and go to WAIT.
  - Flush in DROP: release, so the PC loads the newer target. Stay in DROP unless Mem_Ack.
  - Inst_Valid <= 0 whenever !Id_Stall or Flush.
- **Flush priority.** Flush always forces Inst_Valid <= 0 and Inst_Out <= 0, overriding Id_Stall.
- **Timeout counter.**
  - Counts each WAIT/DROP cycle with Mem_Ack=0.
  - Clears on Mem_Ack and in IDLE/HOLD.
  - Saturates at TIMEOUT. Reaching TIMEOUT sets Fetch_Err, which stays set until Rst.
  - Fetching continues after Fetch_Err is set.

## Timing
- **Reset values.** State=IDLE, Inst_Out=0, Pc_Out=0, Inst_Valid=0, Fetch_Err=0, counter=0, Saved_Addr=0, hold buffer=0.
- **Outputs during Rst.** Mem_Req=0, Pc_Stall=1.
- **Reset mid-operation.** Rst overrides everything. Any outstanding request is abandoned; the first request after reset is issued in the cycle after IDLE.
- **First fetch.** Rst deasserts at edge 0 → IDLE for cycle 0 → Mem_Req=1 in cycle 1.
- **Zero-wait memory (Mem_Ack tied 1).** One instruction per cycle, Pc_Stall=0 every WAIT cycle, no bubbles.
- **Latency.** Inst_Out appears at the edge after the Mem_Ack cycle.
- **N-wait memory.** Pc_Stall=1 for N cycles and Inst_Valid=0 for N cycles per fetch.
- **Memory handshake.** Mem_Addr is stable from request to acknowledge. In WAIT this holds because the PC is stalled; in DROP, Saved_Addr holds it.
- **Simultaneous Mem_Ack and Flush.** The data is never delivered.
- **Buffering.** At most one buffered instruction; HOLD issues no new request.

## Test plan
- **Zero-wait stream.** Rst at PC=0, Mem_Ack=1, RData=addr+0x100. Required: Inst_Valid=1 from the cycle after the first request; Pc_Out = 0, 4, 8… on consecutive cycles; Pc_Stall=0 throughout.
- **Two-wait memory.** Mem_Ack asserted on the 3rd request cycle. Required: Pc_Stall=1 for 2 cycles per fetch, Inst_Valid pattern 0,0,1 repeating, Mem_Addr stable while Mem_Req=1.
- **Id_Stall on ack.** Id_Stall=1 for 3 cycles starting at the Mem_Ack of addr 0x8. Required: outputs hold the 0x4 instruction, state HOLD, Mem_Req=0; the 0x8 instruction appears the cycle after Id_Stall falls.
- **Flush before ack.** Flush at addr 0x10 with memory still busy. Required: Pc_Stall=0 that cycle, DROP with Mem_Addr=0x10 until ack, data discarded, next request at the target, Inst_Valid=0.
- **Flush on ack.** Flush and Mem_Ack in the same cycle. Required: Inst_Valid=0, Inst_Out=0, next Mem_Addr = target.
- **Timeout and reset.** TIMEOUT=4, Mem_Ack=0. Required: Fetch_Err=1 after 4 request cycles and stays set; Rst then clears all outputs and Mem_Req=0 during reset.
